// File: rtl/disp_scan_ctrl.sv
// 8-digit seven-segment scan controller with a double-buffered display value; outputs registered, no skew.
// load_ready stays low from an accepted load until that value commits at frame end; DISP_SCAN_LZB_EN adds leading-zero blanking.
module disp_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned BLANK_CYC = 2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  digit_en,
  input  logic [2:0]  bright,
  output logic [2:0]  digit_sel,
  output logic [3:0]  nibble,
  output logic [7:0]  anodes,
  output logic        frame_done
);

  localparam int unsigned   CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(CLK_DIV - 1);
  localparam logic [35:0]   BLANK_X   = 36'(BLANK_CYC);
  localparam logic [35:0]   SPAN_X    = 36'(CLK_DIV - BLANK_CYC);

  logic [CW-1:0] slot_cnt_q,   slot_cnt_d;
  logic [2:0]    digit_sel_q,  digit_sel_d;
  logic [31:0]   active_q,     active_d;
  logic [31:0]   shadow_q,     shadow_d;
  logic          pending_q,    pending_d;
  logic          load_ready_q, load_ready_d;
  logic [7:0]    anodes_q,     anodes_d;
  logic [3:0]    nibble_q,     nibble_d;
  logic          frame_done_q, frame_done_d;

  logic          frame_end;
  logic          xfer;
  logic [35:0]   win_w;
  logic [35:0]   slot_x;
  logic          lzb_dark;
  logic          lit;

  always_comb begin
    frame_end = (slot_cnt_q == SLOT_LAST) && (digit_sel_q == 3'd7);
    xfer      = load_valid && load_ready_q;

    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d  = '0;
      digit_sel_d = digit_sel_q + 3'd1;
    end else begin
      slot_cnt_d  = slot_cnt_q + CW'(1);
      digit_sel_d = digit_sel_q;
    end

    // Commit and capture cannot collide: capture needs pending clear, commit needs it set.
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (xfer) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
    load_ready_d = !pending_d;

    win_w = (SPAN_X * (36'(bright) + 36'd1)) >> 3;
    if (win_w == 36'd0) begin
      win_w = 36'd1;
    end
    slot_x = 36'(slot_cnt_d);

`ifdef DISP_SCAN_LZB_EN
    lzb_dark = (digit_sel_d != 3'd0) && ((active_d >> {digit_sel_d, 2'b00}) == 32'd0);
`else
    lzb_dark = 1'b0;
`endif

    // Outputs are computed from next-state so digit_sel, nibble and anodes move on the same edge.
    lit = (slot_x >= BLANK_X) && (slot_x < BLANK_X + win_w) &&
          digit_en[digit_sel_d] && !lzb_dark;
    anodes_d = 8'hFF;
    if (lit) begin
      anodes_d[digit_sel_d] = 1'b0;
    end
    nibble_d     = active_d[{digit_sel_d, 2'b00} +: 4];
    frame_done_d = (slot_cnt_d == SLOT_LAST) && (digit_sel_d == 3'd7);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt_q   <= '0;
      digit_sel_q  <= 3'd0;
      active_q     <= 32'd0;
      shadow_q     <= 32'd0;
      pending_q    <= 1'b0;
      load_ready_q <= 1'b1;
      anodes_q     <= 8'hFF;
      nibble_q     <= 4'd0;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_sel_q  <= digit_sel_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      load_ready_q <= load_ready_d;
      anodes_q     <= anodes_d;
      nibble_q     <= nibble_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign digit_sel  = digit_sel_q;
  assign nibble     = nibble_q;
  assign anodes     = anodes_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios plus random traffic against a cycle-count reference model.
module tb_disp_scan_ctrl;

  localparam int CD    = 16;
  localparam int BC    = 2;
  localparam int FRAME = 8 * CD;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] load_data = 32'd0;
  logic        load_valid = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic [2:0]  bright = 3'd7;
  logic        load_ready;
  logic [2:0]  digit_sel;
  logic [3:0]  nibble;
  logic [7:0]  anodes;
  logic        frame_done;

  disp_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digit_en   (digit_en),
    .bright     (bright),
    .digit_sel  (digit_sel),
    .nibble     (nibble),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int          t;
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] m_active;
  logic [31:0] m_shadow;
  bit          m_pending;

  function automatic int win_len(int b);
    int w;
    w = ((CD - BC) * (b + 1)) / 8;
    return (w < 1) ? 1 : w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic check_outputs();
    int   slot;
    int   d;
    bit   on;
    logic [7:0] exp_an;
    slot = t % CD;
    d    = (t / CD) % 8;
    on   = (slot >= BC) && (slot < BC + win_len(int'(bright))) && digit_en[d];
`ifdef DISP_SCAN_LZB_EN
    if (d > 0 && (m_active >> (4 * d)) == 32'd0) on = 1'b0;
`endif
    exp_an = 8'hFF;
    if (on) exp_an[d] = 1'b0;
    chk("digit_sel", 32'(digit_sel), d);
    chk("nibble", 32'(nibble), (m_active >> (4 * d)) & 32'hF);
    chk("anodes", 32'(anodes), 32'(exp_an));
    chk("frame_done", 32'(frame_done), 32'((t % FRAME) == FRAME - 1));
    chk("load_ready", 32'(load_ready), 32'(!m_pending));
  endtask

  task automatic model_reset();
    t         = 0;
    m_active  = 32'd0;
    m_shadow  = 32'd0;
    m_pending = 1'b0;
  endtask

  // Account for the edge that ends cycle t using the inputs now applied, then check cycle t+1.
  task automatic step();
    bit fe;
    bit xfer;
    if (reset) begin
      model_reset();
    end else begin
      fe   = (t % FRAME) == FRAME - 1;
      xfer = load_valid && !m_pending;
      if (fe && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      if (xfer) begin
        m_shadow  = load_data;
        m_pending = 1'b1;
      end
      t++;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic run_to(input int phase);
    while ((t % FRAME) != phase) step();
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    model_reset();
    check_outputs();
    reset = 1'b0;

    // Full brightness timing and frame_done cadence
    repeat (2 * FRAME + 5) step();

    // Minimum and mid brightness windows
    bright = 3'd0;
    repeat (FRAME) step();
    bright = 3'd3;
    repeat (FRAME) step();
    bright = 3'd7;

    // Mid-frame load, with a second offer held while pending
    run_to(60);
    load_data  = 32'h1234ABCD;
    load_valid = 1'b1;
    step();
    load_data = 32'hDEADBEEF;
    repeat (20) step();
    load_valid = 1'b0;
    run_to(FRAME - 1);
    repeat (FRAME + 1) step();

    // Load offered in the frame_done cycle with nothing pending
    run_to(FRAME - 1);
    load_data  = 32'h00005678;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (2 * FRAME) step();

    // Disabled digits keep their slots
    digit_en = 8'b1010_0101;
    bright   = 3'd5;
    repeat (2 * FRAME) step();
    digit_en = 8'hFF;

    // Reset at digit 4 with a pending load
    run_to(10);
    load_data  = 32'h87654321;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    run_to(4 * CD + 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (FRAME + 10) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) bright = 3'($urandom);
      if ($urandom_range(31) == 0) digit_en = 8'($urandom);
      load_valid = ($urandom_range(7) == 0);
      load_data  = $urandom >> $urandom_range(31);
      reset      = ($urandom_range(999) == 0);
      step();
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
